// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// crc_pkg -- shared types, bit-reversal helpers and standard CRC constant sets
// Rev 1.0
// ============================================================================
package crc_pkg;

   // Upper bound on vector widths handled by the reversal helpers.
   localparam int MAX_W = 256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } crc_state_e;

   localparam logic [7:0]  CRC8_POLY          = 8'h07;
   localparam logic [7:0]  CRC8_INIT          = 8'h00;
   localparam logic [7:0]  CRC8_XOR_OUT       = 8'h00;
   localparam logic [15:0] CRC16_CCITT_POLY    = 16'h1021;
   localparam logic [15:0] CRC16_CCITT_INIT    = 16'hFFFF;
   localparam logic [15:0] CRC16_CCITT_XOR_OUT = 16'h0000;
   localparam logic [31:0] CRC32_POLY         = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT         = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOR_OUT      = 32'hFFFFFFFF;

   // Reverse the low w bits of v; bits at and above w return zero.
   function automatic logic [MAX_W-1:0] reverse_bits(input logic [MAX_W-1:0] v, input int w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w) r[i] = v[w-1-i];
      end
      return r;
   endfunction

   // Reverse bit order inside each byte of the low w bits (w a multiple of 8).
   function automatic logic [MAX_W-1:0] reverse_byte_bits(input logic [MAX_W-1:0] v, input int w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w) r[i] = v[(i & ~7) + 7 - (i & 7)];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc_next.sv
`default_nettype none
// ============================================================================
// crc_next -- combinational DW-bit parallel CRC update, MSB-first Galois LFSR
// Rev 1.0
// ============================================================================
module crc_next
   import crc_pkg::*;
#(
   parameter int             DW   = 8,
   parameter int             CW   = 8,
   parameter logic [CW-1:0]  POLY = CW'(8'h07)
) (
   input  logic [DW-1:0] i_data,
   input  logic [CW-1:0] i_seed,
   output logic [CW-1:0] o_crc
);

   logic [CW-1:0] w_aligned;
   logic [CW-1:0] lfsr;
   logic [DW-1:0] pend;
   logic          fb;

   // The first min(DW,CW) data bits are pre-folded into the register so the
   // feedback tap is simply the register MSB.
   generate
      if (DW == CW) begin : g_eq
         assign w_aligned = i_data ^ i_seed;
      end else if (DW < CW) begin : g_lt
         assign w_aligned = {i_data, {(CW-DW){1'b0}}} ^ i_seed;
      end else begin : g_gt
         assign w_aligned = i_data[DW-1 -: CW] ^ i_seed;
      end
   endgenerate

   // Data bits below the folded window enter at the LSB, one per shift.
   always_comb begin
      lfsr = w_aligned;
      pend = i_data << CW;
      fb   = 1'b0;
      for (int k = 0; k < DW; k++) begin
         fb      = lfsr[CW-1];
         lfsr    = lfsr << 1;
         lfsr[0] = pend[DW-1];
         pend    = pend << 1;
         if (fb) lfsr = lfsr ^ POLY;
      end
      o_crc = lfsr;
   end

endmodule
`default_nettype wire

// File: rtl/crc_stream.sv
`default_nettype none
// ============================================================================
// crc_stream -- framed multi-beat CRC engine with held result handshake
// Rev 1.0
// ============================================================================
module crc_stream
   import crc_pkg::*;
#(
   parameter int             DW      = 8,
   parameter int             CW      = 8,
   parameter logic [CW-1:0]  POLY    = CW'(8'h07),
   parameter logic [CW-1:0]  INIT    = '0,
   parameter logic [CW-1:0]  XOR_OUT = '0,
   parameter bit             REFIN   = 1'b0,
   parameter bit             REFOUT  = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          s_last,
   input  logic          s_abort,
   output logic          crc_valid,
   input  logic          crc_ready,
   output logic [CW-1:0] crc_out,
   output logic          busy
);

   crc_state_e    state_q, state_d;
   logic [CW-1:0] crc_reg_q, crc_reg_d;
   logic [CW-1:0] crc_out_q, crc_out_d;

   logic [DW-1:0] w_data_in;
   logic [CW-1:0] w_seed;
   logic [CW-1:0] w_next;
   logic [CW-1:0] w_next_ref;

   generate
      if (REFIN) begin : g_refin
         assign w_data_in = DW'(reverse_byte_bits(MAX_W'(s_data), DW));
      end else begin : g_norefin
         assign w_data_in = s_data;
      end
      if (REFOUT) begin : g_refout
         assign w_next_ref = CW'(reverse_bits(MAX_W'(w_next), CW));
      end else begin : g_norefout
         assign w_next_ref = w_next;
      end
   endgenerate

   assign w_seed = (state_q == ST_IDLE) ? INIT : crc_reg_q;

   crc_next #(
      .DW   (DW),
      .CW   (CW),
      .POLY (POLY)
   ) u_crc_next (
      .i_data (w_data_in),
      .i_seed (w_seed),
      .o_crc  (w_next)
   );

   always_comb begin
      state_d   = state_q;
      crc_reg_d = crc_reg_q;
      crc_out_d = crc_out_q;
      case (state_q)
         ST_IDLE, ST_ACC: begin
            // Abort wins over a coincident beat, which is silently dropped.
            if (s_abort) begin
               crc_reg_d = INIT;
               state_d   = ST_IDLE;
            end else if (s_valid) begin
               if (s_last) begin
                  crc_out_d = w_next_ref ^ XOR_OUT;
                  crc_reg_d = INIT;
                  state_d   = ST_DONE;
               end else begin
                  crc_reg_d = w_next;
                  state_d   = ST_ACC;
               end
            end
         end
         ST_DONE: begin
            if (crc_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            crc_reg_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         crc_reg_q <= INIT;
         crc_out_q <= '0;
      end else begin
         state_q   <= state_d;
         crc_reg_q <= crc_reg_d;
         crc_out_q <= crc_out_d;
      end
   end

   assign s_ready   = (state_q != ST_DONE);
   assign crc_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_ACC);
   assign crc_out   = crc_out_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_stream.sv
`default_nettype none
// ============================================================================
// tb_crc_stream -- self-checking bench: CRC-8 and CRC-32 (8/32-bit beats)
// Rev 1.0
// ============================================================================
module tb_crc_stream;
   import crc_pkg::*;

   typedef logic [7:0] bq_t[$];

   typedef struct packed {
      logic [3:0]  len;
      logic [79:0] bytes;
      logic [7:0]  exp8;
      logic [31:0] exp32;
      logic        has32;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Shared stimulus for the two byte-wide engines
   logic        s_valid = 1'b0, s_last = 1'b0, s_abort = 1'b0, crc_ready = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_ready8, crc_valid8, busy8;
   logic [7:0]  crc_out8;
   logic        s_readyc, crc_validc, busyc;
   logic [31:0] crc_outc;

   // Word-wide CRC-32 engine
   logic        s_valid_w = 1'b0, s_last_w = 1'b0, s_abort_w = 1'b0, crc_ready_w = 1'b0;
   logic [31:0] s_data_w = 32'h0;
   logic        s_ready_w, crc_valid_w, busy_w;
   logic [31:0] crc_out_w;

   int n_cmp  = 0;
   int n_fail = 0;

   crc_stream #(.DW(8), .CW(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00),
                .REFIN(1'b0), .REFOUT(1'b0)) u_crc8 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
      .s_last(s_last), .s_abort(s_abort), .crc_valid(crc_valid8), .crc_ready(crc_ready),
      .crc_out(crc_out8), .busy(busy8));

   crc_stream #(.DW(8), .CW(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .XOR_OUT(CRC32_XOR_OUT),
                .REFIN(1'b1), .REFOUT(1'b1)) u_crc32b (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_readyc), .s_data(s_data),
      .s_last(s_last), .s_abort(s_abort), .crc_valid(crc_validc), .crc_ready(crc_ready),
      .crc_out(crc_outc), .busy(busyc));

   crc_stream #(.DW(32), .CW(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .XOR_OUT(CRC32_XOR_OUT),
                .REFIN(1'b1), .REFOUT(1'b1)) u_crc32w (
      .clk(clk), .rst(rst), .s_valid(s_valid_w), .s_ready(s_ready_w), .s_data(s_data_w),
      .s_last(s_last_w), .s_abort(s_abort_w), .crc_valid(crc_valid_w), .crc_ready(crc_ready_w),
      .crc_out(crc_out_w), .busy(busy_w));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: textbook bit-serial CRC over a byte message.
   function automatic logic [31:0] ref_crc(input bq_t q, input int cw, input logic [31:0] poly,
                                           input logic [31:0] init, input logic [31:0] xo,
                                           input bit refl);
      logic [31:0] mask, crc, rev;
      logic [7:0]  b;
      logic        top;
      mask = (cw == 32) ? 32'hFFFF_FFFF : ((32'h1 << cw) - 32'h1);
      crc  = init & mask;
      foreach (q[i]) begin
         b = q[i];
         if (refl) for (int j = 0; j < 8; j++) b[j] = q[i][7-j];
         for (int j = 7; j >= 0; j--) begin
            top = crc[cw-1] ^ b[j];
            crc = (crc << 1) & mask;
            if (top) crc = crc ^ poly;
         end
      end
      if (refl) begin
         rev = '0;
         for (int j = 0; j < cw; j++) rev[j] = crc[cw-1-j];
         crc = rev;
      end
      return (crc ^ xo) & mask;
   endfunction

   function automatic logic [31:0] ref8(input bq_t q);
      return ref_crc(q, 8, 32'h07, 32'h0, 32'h0, 1'b0);
   endfunction

   function automatic logic [31:0] ref32(input bq_t q);
      return ref_crc(q, 32, CRC32_POLY, CRC32_INIT, CRC32_XOR_OUT, 1'b1);
   endfunction

   task automatic send8(input bq_t q, input bit with_last);
      for (int i = 0; i < q.size(); i++) begin
         s_valid = 1'b1;
         s_data  = q[i];
         s_last  = with_last && (i == q.size() - 1);
         check("ready_in_frame8", s_ready8, 1);
         check("early_valid8", crc_valid8, 0);
         check("early_validc", crc_validc, 0);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic finish8(input logic [7:0] e8, input logic [31:0] e32, input int hold);
      check("valid8", crc_valid8, 1);
      check("validc", crc_validc, 1);
      check("crc_out8", crc_out8, e8);
      check("crc_outc", crc_outc, e32);
      check("busy_done8", busy8, 0);
      // A beat offered while the result is held must never be absorbed.
      if (hold > 0) begin
         s_valid = 1'b1;
         s_data  = 8'hAA;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_out8", crc_out8, e8);
         check("hold_valid8", crc_valid8, 1);
         check("hold_ready8", s_ready8, 0);
         check("hold_outc", crc_outc, e32);
      end
      crc_ready = 1'b1;
      @(posedge clk); #1;
      crc_ready = 1'b0;
      s_valid   = 1'b0;
      check("consumed_valid8", crc_valid8, 0);
      check("consumed_ready8", s_ready8, 1);
      check("consumed_validc", crc_validc, 0);
      check("retained_out8", crc_out8, e8);
   endtask

   task automatic send32(input bq_t q);
      int nw;
      nw = q.size() / 4;
      for (int i = 0; i < nw; i++) begin
         s_valid_w = 1'b1;
         s_data_w  = {q[4*i], q[4*i+1], q[4*i+2], q[4*i+3]};
         s_last_w  = (i == nw - 1);
         check("early_valid_w", crc_valid_w, 0);
         @(posedge clk); #1;
      end
      s_valid_w = 1'b0;
      s_last_w  = 1'b0;
   endtask

   task automatic finish32(input logic [31:0] e, input int hold);
      check("valid_w", crc_valid_w, 1);
      check("crc_out_w", crc_out_w, e);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_out_w", crc_out_w, e);
      end
      crc_ready_w = 1'b1;
      @(posedge clk); #1;
      crc_ready_w = 1'b0;
      check("consumed_valid_w", crc_valid_w, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready8"}, s_ready8, 1);
      check({tag, "_valid8"}, crc_valid8, 0);
      check({tag, "_out8"}, crc_out8, 0);
      check({tag, "_busy8"}, busy8, 0);
      check({tag, "_outc"}, crc_outc, 0);
      check({tag, "_valid_w"}, crc_valid_w, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs [0:2];
      bq_t         q, qs;
      logic [31:0] e8, e32;
      int          len;

      // Vector table: 9-byte check string, single 0x01, single 0x00
      vecs[0] = '{len: 4'd9, bytes: 80'h31323334353637383900, exp8: 8'hF4, exp32: 32'hCBF43926, has32: 1'b1};
      vecs[1] = '{len: 4'd1, bytes: 80'h01000000000000000000, exp8: 8'h07, exp32: 32'h0, has32: 1'b0};
      vecs[2] = '{len: 4'd1, bytes: 80'h00000000000000000000, exp8: 8'h00, exp32: 32'h0, has32: 1'b0};

      qs = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 3; v++) begin
         q = {};
         for (int i = 0; i < int'(vecs[v].len); i++) q.push_back(vecs[v].bytes[79-8*i -: 8]);
         e32 = vecs[v].has32 ? vecs[v].exp32 : ref32(q);
         send8(q, 1'b1);
         finish8(vecs[v].exp8, e32, 0);
      end

      // Backpressure, then a frame starting the cycle right after consume
      send8(qs, 1'b1);
      finish8(8'hF4, 32'hCBF43926, 5);
      q = {8'h01};
      e32 = ref32(q);
      send8(q, 1'b1);
      finish8(8'h07, e32, 0);

      // Abort mid-frame with a coincident (dropped) beat
      send8({8'h31, 8'h32}, 1'b0);
      check("busy_mid8", busy8, 1);
      s_abort = 1'b1; s_valid = 1'b1; s_data = 8'h55;
      @(posedge clk); #1;
      s_abort = 1'b0; s_valid = 1'b0;
      check("abort_busy8", busy8, 0);
      check("abort_busyc", busyc, 0);
      check("abort_valid8", crc_valid8, 0);
      send8(qs, 1'b1);
      finish8(8'hF4, 32'hCBF43926, 0);

      // Abort is ignored while a result is held
      q = {8'h01};
      e32 = ref32(q);
      send8(q, 1'b1);
      s_abort = 1'b1;
      @(posedge clk); #1;
      s_abort = 1'b0;
      finish8(8'h07, e32, 0);

      // Asynchronous reset mid-frame: outputs drop without a clock edge
      send8({8'h31, 8'h32, 8'h33}, 1'b0);
      check("busy_before_rst8", busy8, 1);
      #2 rst = 1'b1;
      #1;
      check_reset_values("rst_mid");
      @(posedge clk); #1;
      rst = 1'b0;
      send8(qs, 1'b1);
      finish8(8'hF4, 32'hCBF43926, 0);

      // Asynchronous reset while a result is pending
      send8({8'h31}, 1'b1);
      check("pending_valid8", crc_valid8, 1);
      #2 rst = 1'b1;
      #1;
      check_reset_values("rst_done");
      @(posedge clk); #1;
      rst = 1'b0;

      // Randomized byte frames, some preceded by an aborted partial frame
      for (int r = 0; r < 30; r++) begin
         if ($urandom_range(0, 3) == 0) begin
            q = {};
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            send8(q, 1'b0);
            s_abort = 1'b1; s_valid = 1'($urandom); s_data = 8'($urandom);
            @(posedge clk); #1;
            s_abort = 1'b0; s_valid = 1'b0;
         end
         q = {};
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         e8  = ref8(q);
         e32 = ref32(q);
         send8(q, 1'b1);
         finish8(e8[7:0], e32, $urandom_range(0, 3));
      end

      // Word-wide engine: "12345678" then random frames
      q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
      send32(q);
      finish32(ref32(q), 2);
      for (int r = 0; r < 15; r++) begin
         q = {};
         len = 4 * $urandom_range(1, 4);
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         e32 = ref32(q);
         send32(q);
         finish32(e32, $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crc_stream.md
Name: crc_stream

Overview:
- Streaming, multi-beat CRC engine: accepts a framed data stream DW bits per beat over a valid/ready handshake.
- Accumulates the CRC across beats, one beat per cycle. The first beat of a frame is seeded with INIT; each later beat is seeded with the running CRC.
- Presents the finalised CRC (optional reflection and output XOR) on a held output handshake.
- Sits between packet sources (MAC/framer) and checkers/appenders; replaces hand-cascaded single-cycle CRC instances.

Parameters:
- DW, 8, data bits per beat (>=1; multiple of 8 when REFIN=1)
- CW, 8, CRC width (>=1)
- POLY, 8'h07, generator polynomial in normal form (implicit x^CW term omitted), CW bits
- INIT, '0, register seed at start of each frame, CW bits
- XOR_OUT, '0, value XOR-ed onto the final CRC, CW bits
- REFIN, 0, 1 = bit-reverse each input byte before processing
- REFOUT, 0, 1 = bit-reverse the whole CW-bit result before XOR_OUT

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  engine can accept a beat
- s_data  in  DW  beat data, MSB processed first
- s_last  in  1  beat is final beat of frame
- s_abort  in  1  synchronous frame discard
- crc_valid  out  1  result available
- crc_ready  in  1  consumer accepts result
- crc_out  out  CW  finalised CRC
- busy  out  1  frame in progress (at least one beat accepted, result not yet produced)

Behaviour:
- Reset (async assert, sync release): state=IDLE, crc_reg=INIT, crc_valid=0, crc_out=0, busy=0, s_ready=1.
- Handshakes:
  - Beat accepted when s_valid && s_ready.
  - Result consumed when crc_valid && crc_ready.
  - Sources must hold s_data/s_last stable while s_valid && !s_ready.
- States:
  - IDLE: waiting for first beat. s_ready=1.
  - ACC: mid-frame. s_ready=1, busy=1.
  - DONE: result held. s_ready=0, crc_valid=1.
- Per accepted beat: seed = (state==IDLE) ? INIT : crc_reg.
  - d = REFIN ? per-byte bit-reversed s_data : s_data.
  - next = crc_next(d, seed): MSB-first Galois LFSR, equivalent to DW serial shifts.
  - Width rules for crc_next:
    - DW==CW: lfsr = d ^ seed.
    - DW<CW: lfsr = {d, zeros} ^ seed.
    - DW>CW: lfsr = d[top CW] ^ seed; remaining DW-CW bits are shifted in.
- Accepted beat with s_last=0:
  - crc_reg <= next.
  - IDLE->ACC, or stay in ACC.
- Accepted beat with s_last=1:
  - crc_out <= (REFOUT ? reverse(next) : next) ^ XOR_OUT.
  - crc_valid <= 1, state -> DONE, crc_reg <= INIT.
  - Latency: crc_valid rises the cycle after the last beat handshake.
- Single-beat frame (first beat has s_last=1): IDLE->DONE directly.
- DONE: crc_out held stable until consumed. On consume: crc_valid <= 0, state -> IDLE. New beats are accepted from the following cycle; there is no same-cycle overlap.
- s_abort=1 in IDLE or ACC: crc_reg <= INIT, state -> IDLE, no result produced.
  - A beat presented in the same cycle is dropped, but s_ready still reads 1, so the source sees it as accepted.
  - s_abort is ignored in DONE.
- rst asserted mid-frame or in DONE: immediate return to reset values; any pending result is lost.
- crc_out retains its last value after consume. It is only meaningful while crc_valid=1.

Decomposition:
- Shared package crc_pkg:
  - function bit-reverse of a vector, and per-byte reverse;
  - state enum {IDLE, ACC, DONE};
  - named POLY/INIT/XOR_OUT constant sets for CRC-8 (07/00/00), CRC-16-CCITT (1021/FFFF/0000), CRC-32 (04C11DB7/FFFFFFFF/FFFFFFFF).
- One sub-module: crc_next. Purely combinational parallel update (DW, CW, POLY), covering the three width cases above.
- crc_stream holds the FSM, crc_reg, output register and reflection/XOR finalisation.

Test Plan:
- CRC-8, DW=8, POLY=07, INIT=00: beats "123456789" (0x31..0x39), last on 0x39 -> crc_out=0xF4, one cycle after the last handshake.
- Same config, single beat 0x01 with s_last=1 -> crc_out=0x07. Single beat 0x00 -> crc_out=0x00.
- CRC-32, DW=32, CW=32, POLY=04C11DB7, INIT=FFFFFFFF, XOR_OUT=FFFFFFFF, REFIN=REFOUT=1:
  - Input: "1234" then "5678" as 32-bit beats, then the final byte padded via a DW=8 instance.
  - Primary check: a DW=8 instance on the 9 bytes -> 0xCBF43926.
- Backpressure: hold crc_ready=0 for 5 cycles after a result.
  - crc_valid and crc_out stay stable; s_ready=0 throughout.
  - Next frame is accepted the cycle after consume; its CRC is unaffected by the prior frame.
- Abort/reset:
  - Abort after beats 0x31,0x32, then send "123456789" -> 0xF4.
  - Assert rst mid-frame -> all outputs return to reset values in the same cycle; the following full frame -> 0xF4.
